m3_phase_drive: RTL and testbench
=================================

Name: m3_phase_drive

Overview:
- Downstream consumer of the step calculator's 4-bit commutation step (0..11 active, 15 idle).
- Maps each step pair to one of 6 commutation sectors and drives the 3-phase bridge through six gate outputs.
- High side is PWM-chopped at a user-adjustable power level. Low side is held solid on.
- Inserts a dead-time blanking window on every sector change, so no bridge leg ever shoots through.

Parameters:
PWM_BITS, 8, width of PWM counter and power level
PWM_TOP, 254, last PWM counter value; period = PWM_TOP+1 cycles
DEADTIME, 8, all-gates-off cycles inserted before any new sector is driven (>=1)
POWER_INIT, 32, power level after reset
POWER_STEP, 4, increment/decrement per power pulse
POWER_MAX, 240, saturation ceiling
POWER_MIN, 0, saturation floor

Ports:
clkI  input  1  system clock
nRstI  input  1  asynchronous active-low reset
stepI  input  4  commutation step from step calculator (0..11 valid, 15 idle)
workingI  input  1  drive enable; 0 forces all gates off
m3forceStopI  input  1  emergency stop, level-sensitive, overrides everything
m3invRotateI  input  1  1 = reverse sector order
m3powerINCi  input  1  single-cycle pulse, raise power
m3powerDECi  input  1  single-cycle pulse, lower power
gateHiO  output  3  high-side gates {C,B,A}
gateLoO  output  3  low-side gates {C,B,A}
powerLevelO  output PWM_BITS  requested power level
drivingO  output  1  1 while FSM in DRIVE

Behaviour:
- Clock and reset: one clock, clkI. Reset nRstI is asynchronous, active-low.
- Reset values:
  - gateHiO=0, gateLoO=0, drivingO=0.
  - powerLevelO=POWER_INIT, active compare=POWER_INIT.
  - pwmCnt=0, FSM=OFF, latched sector=7 (none).
- Sector decode: sector=stepI>>1 for stepI 0..11. If m3invRotateI=1, sector=5-sector.
  - Forward table (hi+/lo-): 0 A+B-, 1 A+C-, 2 B+C-, 3 B+A-, 4 C+A-, 5 C+B-.
  - stepI 12..15 decode to "none".
- Drive condition: "off request" = m3forceStopI | !workingI | sector none.
- FSM OFF:
  - All gates 0.
  - Leave to DEAD when there is no off request, loading deadCnt=DEADTIME-1 and latching the sector.
- FSM DEAD:
  - All gates 0; deadCnt decrements each cycle.
  - At deadCnt==0 go to DRIVE.
  - On an off request go to OFF.
  - On a sector change: relatch the sector and reload deadCnt.
- FSM DRIVE:
  - gateLoO = one-hot of the low phase, held at 1.
  - gateHiO = one-hot of the high phase AND (pwmCnt < active compare).
  - On a decoded sector change go to DEAD: latch the new sector, load deadCnt.
  - On an off request go to OFF.
- Latency:
  - Gate outputs are registered.
  - A step change sampled on edge N turns all gates 0 from edge N+1.
  - The new sector is driven from edge N+1+DEADTIME.
  - Force stop or !workingI sampled on edge N clears the gates at edge N+1 (1 cycle, no dead time needed).
- Direction toggle mid-drive: this is a sector change, so normal dead-time insertion applies.
- Invariant: gateHiO[i] & gateLoO[i] == 0 for all i, every cycle. Also at most one bit set in each of gateHiO and gateLoO.
- PWM counter:
  - Free-running from 0 to PWM_TOP, then wraps to 0. Runs regardless of FSM state.
  - Active compare loads from powerLevelO only when pwmCnt==PWM_TOP (glitch-free duty update).
  - Power level 0 gives high side never on. Power level > PWM_TOP gives always on.
- Power register:
  - INC alone: min(p+POWER_STEP, POWER_MAX).
  - DEC alone: p<POWER_MIN+POWER_STEP ? POWER_MIN : p-POWER_STEP.
  - INC and DEC in the same cycle: no change.
  - Power pulses are accepted in every FSM state, including during force stop.
- Reset mid-operation: all gates drop asynchronously, with no dead-time requirement.

Decomposition:
- Shared package m3_drive_pkg holds:
  - FSM state encoding (OFF, DEAD, DRIVE).
  - Sector "none" code (3'd7).
  - Forward sector table as constants: hi/lo one-hot per sector.
  - Idle step code 4'hF.
- Sub-module m3_sector_decode: purely combinational.
  - Inputs: stepI, m3invRotateI.
  - Outputs: 3-bit sector, hiSel one-hot, loSel one-hot, valid.
- Top level holds the FSM, dead counter, PWM counter and power register.

Test Plan:
- Reset release with stepI=15, workingI=1: gates stay 0, powerLevelO=32, drivingO=0, pwmCnt counts 0..254 and wraps.
- stepI=0 from cycle 10, power 32: gates 0 for cycles 11..18, then gateLoO=3'b010 solid and gateHiO[0] high for 32 of each 255 cycles.
- Walk stepI 0..11 with invRotate=0 then =1: sector sequence 0,0,1,1..5,5 forward and 5,5,4..0 reverse. Every sector change gives exactly 8 all-off cycles. The shoot-through assertion never fires.
- m3forceStopI pulsed during DRIVE: gates 0 next cycle. After release, 8 dead cycles before re-drive.
- 70 INC pulses from 32: saturates at 240. Simultaneous INC+DEC: unchanged. DEC from 2: gives 0. Duty changes only at pwmCnt wrap.
- nRstI asserted mid-DRIVE without clock: gates 0 immediately. After release: power=32, FSM OFF.

Source files
------------

// File: rtl/m3_drive_pkg.sv
`default_nettype none
// ==========================================================================
// m3_drive_pkg : shared encodings and sector tables for the phase driver
// Rev 1.0
// ==========================================================================
package m3_drive_pkg;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_DEAD  = 2'd1,
        ST_DRIVE = 2'd2
    } drive_state_t;

    localparam logic [2:0] SECTOR_NONE = 3'd7;
    localparam logic [3:0] STEP_IDLE   = 4'hF;
    localparam logic [3:0] STEP_LAST   = 4'd11;

    localparam logic [2:0] PH_A = 3'b001;
    localparam logic [2:0] PH_B = 3'b010;
    localparam logic [2:0] PH_C = 3'b100;

    // Forward order, index = sector (element [0] is rightmost)
    localparam logic [5:0][2:0] HI_TABLE = {PH_C, PH_C, PH_B, PH_B, PH_A, PH_A};
    localparam logic [5:0][2:0] LO_TABLE = {PH_B, PH_A, PH_A, PH_C, PH_C, PH_B};

    function automatic logic [2:0] mirror_sector(input logic [2:0] s);
        return 3'd5 - s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/m3_sector_decode.sv
`default_nettype none
// ==========================================================================
// m3_sector_decode : commutation step -> sector and phase one-hots
// Rev 1.0
// ==========================================================================
module m3_sector_decode
    import m3_drive_pkg::*;
(
    input  logic [3:0] stepI,
    input  logic       m3invRotateI,
    output logic [2:0] sector,
    output logic [2:0] hiSel,
    output logic [2:0] loSel,
    output logic       valid
);

    logic [2:0] fwd_sector;

    assign fwd_sector = stepI[3:1];

    always_comb begin
        valid  = (stepI != STEP_IDLE) && (stepI <= STEP_LAST);
        sector = SECTOR_NONE;
        hiSel  = 3'b000;
        loSel  = 3'b000;
        if (valid) begin
            sector = m3invRotateI ? mirror_sector(fwd_sector) : fwd_sector;
            hiSel  = HI_TABLE[sector];
            loSel  = LO_TABLE[sector];
        end
    end

endmodule
`default_nettype wire

// File: rtl/m3_phase_drive.sv
`default_nettype none
// ==========================================================================
// m3_phase_drive : 3-phase bridge driver, PWM high side, dead-time FSM
// Rev 1.0
// ==========================================================================
module m3_phase_drive
    import m3_drive_pkg::*;
#(
    parameter int PWM_BITS   = 8,
    parameter int PWM_TOP    = 254,
    parameter int DEADTIME   = 8,
    parameter int POWER_INIT = 32,
    parameter int POWER_STEP = 4,
    parameter int POWER_MAX  = 240,
    parameter int POWER_MIN  = 0
)(
    input  logic                clkI,
    input  logic                nRstI,
    input  logic [3:0]          stepI,
    input  logic                workingI,
    input  logic                m3forceStopI,
    input  logic                m3invRotateI,
    input  logic                m3powerINCi,
    input  logic                m3powerDECi,
    output logic [2:0]          gateHiO,
    output logic [2:0]          gateLoO,
    output logic [PWM_BITS-1:0] powerLevelO,
    output logic                drivingO
);

    localparam int DEAD_W = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
    localparam int PW     = PWM_BITS + 1;

    localparam logic [DEAD_W-1:0]   DEAD_LOAD = DEAD_W'(DEADTIME - 1);
    localparam logic [PWM_BITS-1:0] CNT_TOP   = PWM_BITS'(PWM_TOP);
    localparam logic [PWM_BITS-1:0] P_INIT    = PWM_BITS'(POWER_INIT);
    localparam logic [PW-1:0]       P_STEP    = PW'(POWER_STEP);
    localparam logic [PW-1:0]       P_MAX     = PW'(POWER_MAX);
    localparam logic [PW-1:0]       P_MIN     = PW'(POWER_MIN);

    logic [2:0]          dec_sector;
    logic [2:0]          dec_hi;
    logic [2:0]          dec_lo;
    logic                dec_valid;

    drive_state_t        state;
    drive_state_t        state_nxt;
    logic [DEAD_W-1:0]   dead_cnt;
    logic [DEAD_W-1:0]   dead_nxt;
    logic                latch_sector;
    logic [2:0]          sec_q;
    logic [2:0]          hi_q;
    logic [2:0]          lo_q;

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] cmp_level;
    logic [PWM_BITS-1:0] power;
    logic [PW-1:0]       inc_sum;
    logic [PWM_BITS-1:0] inc_val;
    logic [PWM_BITS-1:0] dec_val;

    logic                off_req;
    logic                sec_change;
    logic                pwm_on;

    m3_sector_decode u_decode (
        .stepI        (stepI),
        .m3invRotateI (m3invRotateI),
        .sector       (dec_sector),
        .hiSel        (dec_hi),
        .loSel        (dec_lo),
        .valid        (dec_valid)
    );

    assign off_req    = m3forceStopI | ~workingI | ~dec_valid;
    assign sec_change = (dec_sector != sec_q);
    assign pwm_on     = (pwm_cnt < cmp_level);

    // ---------------- FSM ----------------
    always_ff @(posedge clkI or negedge nRstI) begin
        if (!nRstI) begin
            state    <= ST_OFF;
            dead_cnt <= '0;
            sec_q    <= SECTOR_NONE;
            hi_q     <= 3'b000;
            lo_q     <= 3'b000;
        end else begin
            state    <= state_nxt;
            dead_cnt <= dead_nxt;
            if (latch_sector) begin
                sec_q <= dec_sector;
                hi_q  <= dec_hi;
                lo_q  <= dec_lo;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        dead_nxt     = dead_cnt;
        latch_sector = 1'b0;
        case (state)
            ST_OFF: begin
                if (!off_req) begin
                    state_nxt    = ST_DEAD;
                    dead_nxt     = DEAD_LOAD;
                    latch_sector = 1'b1;
                end
            end
            ST_DEAD: begin
                // A new sector restarts the blanking window from scratch
                if (off_req) begin
                    state_nxt = ST_OFF;
                end else if (sec_change) begin
                    dead_nxt     = DEAD_LOAD;
                    latch_sector = 1'b1;
                end else if (dead_cnt == '0) begin
                    state_nxt = ST_DRIVE;
                end else begin
                    dead_nxt = dead_cnt - 1'b1;
                end
            end
            ST_DRIVE: begin
                if (off_req) begin
                    state_nxt = ST_OFF;
                end else if (sec_change) begin
                    state_nxt    = ST_DEAD;
                    dead_nxt     = DEAD_LOAD;
                    latch_sector = 1'b1;
                end
            end
            default: state_nxt = ST_OFF;
        endcase
    end

    assign drivingO = (state == ST_DRIVE);

    // Gates follow the registered state, so any exit from DRIVE blanks them next edge
    always_ff @(posedge clkI or negedge nRstI) begin
        if (!nRstI) begin
            gateHiO <= 3'b000;
            gateLoO <= 3'b000;
        end else if (state == ST_DRIVE) begin
            gateHiO <= hi_q & {3{pwm_on}};
            gateLoO <= lo_q;
        end else begin
            gateHiO <= 3'b000;
            gateLoO <= 3'b000;
        end
    end

    // ---------------- PWM ----------------
    always_ff @(posedge clkI or negedge nRstI) begin
        if (!nRstI) begin
            pwm_cnt   <= '0;
            cmp_level <= P_INIT;
        end else if (pwm_cnt == CNT_TOP) begin
            pwm_cnt   <= '0;
            cmp_level <= power;
        end else begin
            pwm_cnt   <= pwm_cnt + 1'b1;
        end
    end

    // ---------------- Power level ----------------
    assign inc_sum = {1'b0, power} + P_STEP;
    assign inc_val = (inc_sum > P_MAX) ? P_MAX[PWM_BITS-1:0] : inc_sum[PWM_BITS-1:0];
    assign dec_val = ({1'b0, power} < (P_MIN + P_STEP)) ? P_MIN[PWM_BITS-1:0]
                                                        : power - P_STEP[PWM_BITS-1:0];

    always_ff @(posedge clkI or negedge nRstI) begin
        if (!nRstI) begin
            power <= P_INIT;
        end else if (m3powerINCi && !m3powerDECi) begin
            power <= inc_val;
        end else if (m3powerDECi && !m3powerINCi) begin
            power <= dec_val;
        end
    end

    assign powerLevelO = power;

endmodule
`default_nettype wire

// File: tb/tb_m3_phase_drive.sv
`default_nettype none
// ==========================================================================
// tb_m3_phase_drive : scoreboard bench, expectations keyed by clock edge
// Rev 1.0
// ==========================================================================
module tb_m3_phase_drive;

    localparam int PERIOD  = 255;
    localparam int K_GATES = 0;
    localparam int K_PWR   = 1;
    localparam int K_DRV   = 2;

    typedef struct {
        int         cyc;
        int         kind;
        logic [2:0] hi;
        logic [2:0] lo;
        logic [7:0] val;
    } exp_t;

    logic       clkI = 1'b0;
    logic       nRstI = 1'b0;
    logic [3:0] stepI = 4'hF;
    logic       workingI = 1'b1;
    logic       m3forceStopI = 1'b0;
    logic       m3invRotateI = 1'b0;
    logic       m3powerINCi = 1'b0;
    logic       m3powerDECi = 1'b0;
    logic [2:0] gateHiO;
    logic [2:0] gateLoO;
    logic [7:0] powerLevelO;
    logic       drivingO;

    int   cyc;
    int   checks = 0;
    int   fails = 0;
    exp_t sb[$];

    logic [2:0] hi_tab [6] = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100};
    logic [2:0] lo_tab [6] = '{3'b010, 3'b100, 3'b100, 3'b001, 3'b001, 3'b010};

    m3_phase_drive dut (
        .clkI         (clkI),
        .nRstI        (nRstI),
        .stepI        (stepI),
        .workingI     (workingI),
        .m3forceStopI (m3forceStopI),
        .m3invRotateI (m3invRotateI),
        .m3powerINCi  (m3powerINCi),
        .m3powerDECi  (m3powerDECi),
        .gateHiO      (gateHiO),
        .gateLoO      (gateLoO),
        .powerLevelO  (powerLevelO),
        .drivingO     (drivingO)
    );

    always #5 clkI = ~clkI;

    // Edge index since reset release: edge 1 is the first posedge with nRstI high
    always @(posedge clkI or negedge nRstI) begin
        if (!nRstI) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", name, cyc, got, want);
        end
    endtask

    task automatic push(input int c, input int k, input logic [2:0] h,
                        input logic [2:0] l, input logic [7:0] v);
        exp_t e;
        e.cyc = c; e.kind = k; e.hi = h; e.lo = l; e.val = v;
        sb.push_back(e);
    endtask

    task automatic exp_off(input int c);
        push(c, K_GATES, 3'b000, 3'b000, 8'h00);
    endtask

    // Gate at edge c uses the PWM count from before that edge: (c-1) mod 255
    task automatic exp_drive(input int c, input int sec, input int duty);
        logic [2:0] h;
        h = (((c - 1) % PERIOD) < duty) ? hi_tab[sec] : 3'b000;
        push(c, K_GATES, h, lo_tab[sec], 8'h00);
    endtask

    task automatic to_edge(input int n);
        while (cyc < n) begin
            @(posedge clkI);
            #1;
        end
    endtask

    // Monitor: compare every expectation due at this edge, plus the bridge invariant
    always @(negedge clkI) begin
        if (nRstI) begin
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc == cyc) begin
                    case (sb[i].kind)
                        K_GATES: check("gates{hi,lo}", {26'd0, gateHiO, gateLoO}, {26'd0, sb[i].hi, sb[i].lo});
                        K_PWR:   check("power_level", {24'd0, powerLevelO}, {24'd0, sb[i].val});
                        default: check("driving", {31'd0, drivingO}, {31'd0, sb[i].val[0]});
                    endcase
                    sb.delete(i);
                end else if (sb[i].cyc < cyc) begin
                    checks++;
                    fails++;
                    $display("FAIL missed_expectation for edge %0d kind %0d", sb[i].cyc, sb[i].kind);
                    sb.delete(i);
                end
            end
        end
        checks++;
        if (((gateHiO & gateLoO) != 3'b000) || !$onehot0(gateHiO) || !$onehot0(gateLoO)) begin
            fails++;
            $display("FAIL shoot_through at edge %0d: hi=%b lo=%b, required disjoint one-hot", cyc, gateHiO, gateLoO);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit expired at edge %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int vstep [25];
        int vinv  [25];
        int prev_sec;
        int sec;
        int e;
        int exp_p;
        int p;
        int q;
        int r;
        int w;

        // Idle after reset: gates off, default power, not driving
        for (int k = 1; k <= 8; k++) begin
            exp_off(k);
            push(k, K_PWR, 3'b000, 3'b000, 8'd32);
            push(k, K_DRV, 3'b000, 3'b000, 8'd0);
        end
        #22 nRstI = 1'b1;

        // First sector: step 0 sampled on edge 10, driven from edge 19
        to_edge(9);
        stepI = 4'd0;
        for (int k = 10; k <= 18; k++) exp_off(k);
        push(17, K_DRV, 3'b000, 3'b000, 8'd0);
        push(18, K_DRV, 3'b000, 3'b000, 8'd1);
        for (int k = 19; k <= 765; k++) exp_drive(k, 0, (k <= 510) ? 32 : 36);

        // Power change mid-period takes effect only from the wrap at edge 510
        push(299, K_PWR, 3'b000, 3'b000, 8'd32);
        push(300, K_PWR, 3'b000, 3'b000, 8'd36);
        to_edge(299);
        m3powerINCi = 1'b1;
        to_edge(300);
        m3powerINCi = 1'b0;

        // Walk forward, then reverse, then a direction toggle
        for (int v = 0; v < 12; v++) begin
            vstep[v] = v;      vinv[v] = 0;
            vstep[v + 12] = v; vinv[v + 12] = 1;
        end
        vstep[24] = 11; vinv[24] = 0;
        prev_sec = 0;
        for (int v = 0; v < 25; v++) begin
            e = 770 + 12 * v;
            to_edge(e);
            stepI = 4'(vstep[v]);
            m3invRotateI = vinv[v][0];
            sec = vstep[v] / 2;
            if (vinv[v] != 0) sec = 5 - sec;
            if (sec != prev_sec) begin
                exp_drive(e + 1, prev_sec, 36);
                for (int k = e + 2; k <= e + 9; k++) exp_off(k);
                for (int k = e + 10; k <= e + 12; k++) exp_drive(k, sec, 36);
                push(e + 1, K_DRV, 3'b000, 3'b000, 8'd0);
                push(e + 9, K_DRV, 3'b000, 3'b000, 8'd1);
            end else begin
                for (int k = e + 1; k <= e + 12; k++) exp_drive(k, sec, 36);
            end
            prev_sec = sec;
        end

        // Force stop during drive, with power pulses accepted while stopped
        to_edge(1070);
        m3forceStopI = 1'b1;
        exp_drive(1071, 5, 36);
        push(1071, K_DRV, 3'b000, 3'b000, 8'd0);
        for (int k = 1072; k <= 1084; k++) exp_off(k);
        for (int k = 1085; k <= 1091; k++) exp_drive(k, 5, 36);
        push(1073, K_PWR, 3'b000, 3'b000, 8'd40);
        push(1074, K_PWR, 3'b000, 3'b000, 8'd36);
        to_edge(1072);
        m3powerINCi = 1'b1;
        to_edge(1073);
        m3powerINCi = 1'b0;
        m3powerDECi = 1'b1;
        to_edge(1074);
        m3powerDECi = 1'b0;
        to_edge(1075);
        m3forceStopI = 1'b0;

        // Drive enable dropped for one cycle
        for (int k = 1092; k <= 1101; k++) exp_off(k);
        for (int k = 1102; k <= 1105; k++) exp_drive(k, 5, 36);
        to_edge(1090);
        workingI = 1'b0;
        to_edge(1092);
        workingI = 1'b1;

        // 70 INC pulses from 36 saturate at 240
        p = 1110;
        for (int i = 0; i < 70; i++) begin
            to_edge(p + 2 * i);
            exp_p = 36 + 4 * (i + 1);
            if (exp_p > 240) exp_p = 240;
            push(p + 2 * i + 1, K_PWR, 3'b000, 3'b000, 8'(exp_p));
            m3powerINCi = 1'b1;
            to_edge(p + 2 * i + 1);
            m3powerINCi = 1'b0;
        end
        q = p + 140;
        to_edge(q);
        push(q + 1, K_PWR, 3'b000, 3'b000, 8'd240);
        m3powerINCi = 1'b1;
        m3powerDECi = 1'b1;
        to_edge(q + 1);
        m3powerINCi = 1'b0;
        m3powerDECi = 1'b0;

        // 61 DEC pulses floor at 0
        r = q + 2;
        for (int i = 0; i < 61; i++) begin
            to_edge(r + 2 * i);
            exp_p = 240 - 4 * (i + 1);
            if (exp_p < 0) exp_p = 0;
            push(r + 2 * i + 1, K_PWR, 3'b000, 3'b000, 8'(exp_p));
            m3powerDECi = 1'b1;
            to_edge(r + 2 * i + 1);
            m3powerDECi = 1'b0;
        end

        // Power 0: high side never on for a full period after the next wrap
        w = ((r + 122) / PERIOD + 1) * PERIOD;
        for (int k = w + 1; k <= w + PERIOD; k++) exp_drive(k, 5, 0);
        to_edge(w + PERIOD + 5);

        // Asynchronous reset while driving
        @(negedge clkI);
        #2;
        check("pre_reset_lo", {29'd0, gateLoO}, 32'h2);
        nRstI = 1'b0;
        #1;
        check("async_reset_gates", {26'd0, gateHiO, gateLoO}, 32'h0);
        check("async_reset_driving", {31'd0, drivingO}, 32'h0);
        check("async_reset_power", {24'd0, powerLevelO}, 32'd32);
        repeat (3) @(posedge clkI);
        @(negedge clkI);
        #1;
        nRstI = 1'b1;
        push(1, K_PWR, 3'b000, 3'b000, 8'd32);
        push(1, K_DRV, 3'b000, 3'b000, 8'd0);
        push(9, K_DRV, 3'b000, 3'b000, 8'd1);
        for (int k = 1; k <= 9; k++) exp_off(k);
        for (int k = 10; k <= 12; k++) exp_drive(k, 5, 32);
        to_edge(15);
        @(negedge clkI);
        #1;

        while (sb.size() > 0) begin
            checks++;
            fails++;
            $display("FAIL unchecked_expectation for edge %0d kind %0d", sb[0].cyc, sb[0].kind);
            void'(sb.pop_front());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
